regfile_mp: RTL



---
 rtl/regfile_mp.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: two combinational read ports, two write ports,
// a per-register pending (scoreboard) bit, and a self-clearing init sequence.
module regfile_mp #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned NREG        = 32,
  parameter int unsigned BYPASS      = 1,
  parameter int unsigned debug_param = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [$clog2(NREG)-1:0]   rd_addr_a,
  input  logic [$clog2(NREG)-1:0]   rd_addr_b,
  output logic [XLEN-1:0]           rd_data_a,
  output logic [XLEN-1:0]           rd_data_b,
  output logic                      rd_busy_a,
  output logic                      rd_busy_b,
  input  logic                      wr0_en,
  input  logic [$clog2(NREG)-1:0]   wr0_addr,
  input  logic [XLEN-1:0]           wr0_data,
  input  logic                      wr1_en,
  input  logic [$clog2(NREG)-1:0]   wr1_addr,
  input  logic [XLEN-1:0]           wr1_data,
  input  logic                      sb_set_en,
  input  logic [$clog2(NREG)-1:0]   sb_set_addr,
  output logic                      init_done
);

  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   init_cnt_q, init_cnt_d;
  logic            init_done_q, init_done_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;

  logic            run;
  logic            wr0_ok, wr1_ok, sb_ok;
  logic [AW-1:0]   raddr [2];
  logic [XLEN-1:0] rdata [2];
  logic            rbusy [2];

  // Index 0 is hardwired to zero and indices past NREG do not exist.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < NREG);
  endfunction

  assign run    = (state_q == ST_RUN);
  assign wr0_ok = run && wr0_en && addr_ok(wr0_addr);
  assign wr1_ok = run && wr1_en && addr_ok(wr1_addr);
  assign sb_ok  = run && sb_set_en && addr_ok(sb_set_addr);

  // Clear sequence walks every entry once, then the FSM parks in RUN.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (32'(init_cnt_q) == NREG - 1) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
    init_done_d = (state_d == ST_RUN);
  end

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (!run) regs_d[init_cnt_q] = '0;
    if (wr0_ok) regs_d[wr0_addr] = wr0_data;
    if (wr1_ok) regs_d[wr1_addr] = wr1_data;
  end

  // A new producer issued in the same cycle as a writeback keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wr0_ok) pend_d[wr0_addr] = 1'b0;
    if (wr1_ok) pend_d[wr1_addr] = 1'b0;
    if (sb_ok)  pend_d[sb_set_addr] = 1'b1;
  end

  assign raddr[0] = rd_addr_a;
  assign raddr[1] = rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic hit0, hit1;
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      hit0     = (BYPASS != 0) && wr0_ok && (wr0_addr == raddr[p]);
      hit1     = (BYPASS != 0) && wr1_ok && (wr1_addr == raddr[p]);
      if (run && addr_ok(raddr[p])) begin
        rdata[p] = hit1 ? wr1_data : (hit0 ? wr0_data : regs_q[raddr[p]]);
        rbusy[p] = pend_q[raddr[p]] && !(hit0 || hit1);
      end
    end
  end

  assign rd_data_a = rdata[0];
  assign rd_data_b = rdata[1];
  assign rd_busy_a = rbusy[0];
  assign rd_busy_b = rbusy[1];
  assign init_done = init_done_q;

  // Register contents hold during reset; the clear sequence wipes them afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
      regs_q      <= regs_d;
    end
  end

`ifndef SYNTHESIS
  if (debug_param != 0) begin : g_dump
    always @(negedge clk) begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (regs_q[i] != '0)
          $display("regfile_mp x%0d = 0x%h (%0d)", i, regs_q[i], $signed(regs_q[i]));
      end
    end
  end
`endif

endmodule
